// File: rtl/instr_fetch_unit_if.sv
// Instruction fetch bus bundle.
// Carries three groups of signals between the fetch unit and its neighbours:
//   imem_*   : one-outstanding read port to instruction memory
//   instr_*  : valid/ready instruction stream to iDecode
//   br_*, uncondbranch, branch, zero : branch resolution from decode/execute
// modport master : the fetch unit side
// modport slave  : the environment side (memory, decode, branch resolver)
interface instr_fetch_unit_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    logic [INSTR_W-1:0] instr_out;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready;

    logic               br_valid;
    logic [ADDR_W-1:0]  br_pc;
    logic [ADDR_W-1:0]  br_offset;
    logic               uncondbranch;
    logic               branch;
    logic               zero;

    modport master (
        output imem_req, imem_addr, instr_out, instr_pc, instr_valid,
        input  imem_ack, imem_rdata, instr_ready,
               br_valid, br_pc, br_offset, uncondbranch, branch, zero
    );

    modport slave (
        input  imem_req, imem_addr, instr_out, instr_pc, instr_valid,
        output imem_ack, imem_rdata, instr_ready,
               br_valid, br_pc, br_offset, uncondbranch, branch, zero
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit.
// Owns the PC, issues single-outstanding reads to instruction memory, buffers
// returned words with their PCs in a small FIFO and hands them to decode under
// valid/ready. A taken branch redirects the PC, flushes the FIFO and discards
// any read still in flight.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : instr_fetch_unit_if.master (memory, decode and branch signals)
module instr_fetch_unit #(
    parameter int                ADDR_W     = 64,
    parameter int                INSTR_W    = 32,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    instr_fetch_unit_if.master   bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               imem_req_q, imem_req_d;
    logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [INSTR_W-1:0] fifo_instr_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]  fifo_pc_q    [FIFO_DEPTH];

    logic               taken;
    logic [ADDR_W-1:0]  target;
    logic               push;
    logic               pop;

    always_comb begin
        taken  = bus.br_valid & (bus.uncondbranch | (bus.branch & bus.zero));
        target = bus.br_pc + (bus.br_offset << 2);

        state_d     = state_q;
        pc_d        = pc_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        push        = 1'b0;
        pop         = (count_q != '0) && bus.instr_ready;

        case (state_q)
            IDLE: begin
                // Nothing is outstanding here, so count alone bounds the issue.
                // A redirect this cycle suppresses the issue so the next
                // request goes out to the new target.
                if (!taken && (count_q < DEPTH_C)) begin
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc_q;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (bus.imem_ack) begin
                    imem_req_d = 1'b0;
                    state_d    = IDLE;
                    if (!taken) begin
                        push = 1'b1;
                        pc_d = pc_q + ADDR_W'(4);
                    end
                end else if (taken) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Keep the old request up until memory completes it; data dropped.
                if (bus.imem_ack) begin
                    imem_req_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (taken) pc_d = target;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (taken) begin
            // Flush wins over any same-cycle push or pop.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (!push && pop) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            if (push) begin
                fifo_instr_q[wr_ptr_q] <= bus.imem_rdata;
                fifo_pc_q[wr_ptr_q]    <= imem_addr_q;
            end
        end
    end

    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = imem_addr_q;
    // Head is read from storage registers only; no path from imem_rdata.
    assign bus.instr_out   = fifo_instr_q[rd_ptr_q];
    assign bus.instr_pc    = fifo_pc_q[rd_ptr_q];
    assign bus.instr_valid = (count_q != '0);
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(64), .INSTR_W(32)) bus ();

    instr_fetch_unit #(.ADDR_W(64), .INSTR_W(32), .FIFO_DEPTH(2), .RESET_PC(64'd0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;
    int lat = 1;
    int mcnt = 0;
    logic req_seen = 1'b0;
    logic [63:0] exp_q[$];   // scoreboard: expected PCs in delivery order
    logic [63:0] iss_q[$];   // addresses of each newly raised request

    // Memory model: ack 'lat' cycles after the request is first seen.
    always @(negedge clk) begin
        if (!reset_n || !bus.imem_req) begin
            mcnt <= 0;
            bus.imem_ack <= 1'b0;
        end else begin
            mcnt <= mcnt + 1;
            if (mcnt + 1 == lat) begin
                bus.imem_ack   <= 1'b1;
                bus.imem_rdata <= bus.imem_addr[31:0] ^ 32'hA5A5_0000;
            end else begin
                bus.imem_ack <= 1'b0;
            end
        end
        if (reset_n && bus.imem_req && !req_seen) iss_q.push_back(bus.imem_addr);
        req_seen <= reset_n && bus.imem_req;
    end

    // Scoreboard: compare every accepted instruction while expectations are queued.
    always @(negedge clk) begin
        if (reset_n && bus.instr_valid && bus.instr_ready && exp_q.size() != 0) begin
            logic [63:0] epc;
            epc = exp_q.pop_front();
            checks++;
            if (bus.instr_pc !== epc || bus.instr_out !== (epc[31:0] ^ 32'hA5A5_0000)) begin
                failures++;
                $display("FAIL deliver: got pc=%h instr=%h, required pc=%h instr=%h",
                         bus.instr_pc, bus.instr_out, epc, epc[31:0] ^ 32'hA5A5_0000);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_br(input logic v, input logic u, input logic b, input logic z,
                            input logic [63:0] pc, input logic [63:0] off);
        bus.br_valid = v; bus.uncondbranch = u; bus.branch = b; bus.zero = z;
        bus.br_pc = pc; bus.br_offset = off;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive_br(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        exp_q.delete();
        cyc(2);
        iss_q.delete();
        reset_n = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin cyc(1); n++; end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d expected deliveries missing, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.instr_ready = 1'b1;
        drive_br(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        cyc(2);
        checks += 5;
        if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b required 0", bus.imem_req); end
        if (bus.imem_addr !== 64'd0) begin failures++; $display("FAIL rst_addr: got %h required 0", bus.imem_addr); end
        if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b required 0", bus.instr_valid); end
        if (bus.instr_out !== 32'd0) begin failures++; $display("FAIL rst_instr: got %h required 0", bus.instr_out); end
        if (bus.instr_pc !== 64'd0) begin failures++; $display("FAIL rst_pc: got %h required 0", bus.instr_pc); end
        reset_n = 1'b1;
        checks++;
        if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL rel_req_early: got %b required 0", bus.imem_req); end
        cyc(1);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'd0)
            begin failures++; $display("FAIL rel_first_req: got req=%b addr=%h required req=1 addr=0", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_stream();
        lat = 1; bus.instr_ready = 1'b1;
        do_reset();
        exp_q = '{64'h0, 64'h4, 64'h8, 64'hC};
        wait_drain("stream");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (iss_q.size() <= i || iss_q[i] !== 64'(4 * i)) begin
                failures++;
                $display("FAIL stream_addr%0d: got %h required %h", i, (iss_q.size() > i) ? iss_q[i] : 64'hX, 64'(4 * i));
            end
        end
    endtask

    task automatic test_stall();
        lat = 1; bus.instr_ready = 1'b0;
        do_reset();
        cyc(10);
        checks += 4;
        if (iss_q.size() != 2) begin failures++; $display("FAIL stall_nreq: got %0d required 2", iss_q.size()); end
        else if (iss_q[0] !== 64'h0 || iss_q[1] !== 64'h4)
            begin failures++; $display("FAIL stall_addrs: got %h,%h required 0,4", iss_q[0], iss_q[1]); end
        if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL stall_req: got %b required 0", bus.imem_req); end
        if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL stall_valid: got %b required 1", bus.instr_valid); end
        if (bus.instr_pc !== 64'h0) begin failures++; $display("FAIL stall_head: got %h required 0", bus.instr_pc); end
        exp_q = '{64'h0, 64'h4, 64'h8};
        bus.instr_ready = 1'b1;
        wait_drain("stall");
    endtask

    task automatic test_branch_uncond();
        lat = 1; bus.instr_ready = 1'b0;
        do_reset();
        cyc(10);
        iss_q.delete();
        drive_br(1'b1, 1'b1, 1'b0, 1'b0, 64'h10, 64'hFFFF_FFFF_FFFF_FFFE);
        cyc(1);
        drive_br(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        checks++;
        if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL ubr_flush: got valid=%b required 0", bus.instr_valid); end
        exp_q = '{64'h8, 64'hC};
        bus.instr_ready = 1'b1;
        cyc(1);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h8)
            begin failures++; $display("FAIL ubr_target: got req=%b addr=%h required req=1 addr=8", bus.imem_req, bus.imem_addr); end
        wait_drain("ubr");
    endtask

    task automatic test_cbz_drain();
        lat = 1; bus.instr_ready = 1'b0;
        do_reset();
        cyc(10);
        lat = 3;
        drive_br(1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 64'h8);   // redirect to 0x20
        cyc(1);
        drive_br(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        cyc(1);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h20)
            begin failures++; $display("FAIL cbz_req20: got req=%b addr=%h required req=1 addr=20", bus.imem_req, bus.imem_addr); end
        drive_br(1'b1, 1'b0, 1'b1, 1'b1, 64'h40, 64'h4);  // taken CBZ -> 0x50
        cyc(1);
        drive_br(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        iss_q.delete();
        exp_q = '{64'h50};
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h20)
                begin failures++; $display("FAIL cbz_hold%0d: got req=%b addr=%h required req=1 addr=20", i, bus.imem_req, bus.imem_addr); end
            cyc(1);
        end
        wait_drain("cbz");
        checks++;
        if (iss_q.size() == 0 || iss_q[0] !== 64'h50)
            begin failures++; $display("FAIL cbz_target: got %h required 50", (iss_q.size() > 0) ? iss_q[0] : 64'hX); end
    endtask

    task automatic test_not_taken();
        lat = 1; bus.instr_ready = 1'b1;
        do_reset();
        exp_q = '{64'h0, 64'h4, 64'h8, 64'hC, 64'h10};
        cyc(3);
        drive_br(1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0);
        cyc(4);
        drive_br(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        wait_drain("nt");
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (iss_q.size() <= i || iss_q[i] !== 64'(4 * i)) begin
                failures++;
                $display("FAIL nt_addr%0d: got %h required %h", i, (iss_q.size() > i) ? iss_q[i] : 64'hX, 64'(4 * i));
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        lat = 3; bus.instr_ready = 1'b0;
        do_reset();
        while (!(bus.imem_req === 1'b1 && bus.instr_valid === 1'b1) && n < 50) begin cyc(1); n++; end
        checks++;
        if (n >= 50) begin failures++; $display("FAIL mid_setup: req/valid never both high within 50 cycles"); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0)
            begin failures++; $display("FAIL mid_async: got req=%b valid=%b required 0,0", bus.imem_req, bus.instr_valid); end
        cyc(3);
        checks++;
        if (bus.imem_req !== 1'b0 || bus.imem_addr !== 64'd0)
            begin failures++; $display("FAIL mid_hold: got req=%b addr=%h required 0,0", bus.imem_req, bus.imem_addr); end
        iss_q.delete();
        lat = 1; bus.instr_ready = 1'b1;
        exp_q = '{64'h0};
        reset_n = 1'b1;
        wait_drain("mid");
        checks++;
        if (iss_q.size() == 0 || iss_q[0] !== 64'h0)
            begin failures++; $display("FAIL mid_first: got %h required 0", (iss_q.size() > 0) ? iss_q[0] : 64'hX); end
    endtask

    initial begin
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        bus.instr_ready = 1'b0;
        drive_br(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        test_reset();
        test_stream();
        test_stall();
        test_branch_uncond();
        test_cbz_drain();
        test_not_taken();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
